note_tone_gen: RTL and testbench

Audio output stage for the music engine. Consumes the 5-bit note index from the melody sequencer: semitones 0..24 above C4, with index 25 and above meaning rest. Drives a 50 %-duty square wave at the matching pitch onto the 1-bit speaker pin. Restarts the waveform phase cleanly on every note change and holds the pin low during rests.

---
 rtl/tone_pkg.sv | 36 +++
 rtl/tone_half_period_cnt.sv | 31 +++
 rtl/note_tone_gen.sv | 155 +++++++++++++++
 tb/tb_note_tone_gen.sv | 174 +++++++++++++++++
 4 files changed

// File: rtl/tone_pkg.sv
// Shared constants, divider table and FSM encoding for note_tone_gen.
// No ports. HALF_PERIOD[n] = round(50 MHz / (2 * 261.626 Hz * 2^(n/12))),
// the half period in clk cycles of semitone n above C4.
package tone_pkg;

  localparam int unsigned NOTE_W    = 5;
  localparam int unsigned DIV_W     = 17;
  localparam int unsigned GAP_W     = 20;
  localparam int unsigned NUM_NOTES = 25;

  // First index that means rest; 25..31 are all silent.
  localparam logic [NOTE_W-1:0] NOTE_REST = NOTE_W'(25);

  localparam logic [DIV_W-1:0] HALF_PERIOD [0:NUM_NOTES-1] = '{
    17'd95556, 17'd90193, 17'd85131, 17'd80353, 17'd75843,
    17'd71586, 17'd67568, 17'd63776, 17'd60197, 17'd56818,
    17'd53629, 17'd50619, 17'd47778, 17'd45097, 17'd42565,
    17'd40176, 17'd37922, 17'd35793, 17'd33784, 17'd31888,
    17'd30098, 17'd28409, 17'd26815, 17'd25310, 17'd23889
  };

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_GAP  = 2'd1,
    ST_RUN  = 2'd2
  } tone_state_t;

  // Divider lookup; rests return 0 and are never loaded.
  function automatic logic [DIV_W-1:0] half_period(input logic [NOTE_W-1:0] n);
    logic [DIV_W-1:0] r;
    r = '0;
    if (n < NOTE_REST) r = HALF_PERIOD[n];
    return r;
  endfunction

endpackage

// File: rtl/tone_half_period_cnt.sv
// Loadable half-period down-counter.
// Ports: clk, rst_n (async, active-low); load/load_val reload the count
// (load wins over enable); enable decrements by one; zero flags count == 0.
module tone_half_period_cnt
  import tone_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [DIV_W-1:0] load_val,
  input  logic             enable,
  output logic             zero
);

  logic [DIV_W-1:0] cnt_q, cnt_d;

  // Next count: reload has priority over decrement.
  always_comb begin
    cnt_d = cnt_q;
    if (load)        cnt_d = load_val;
    else if (enable) cnt_d = cnt_q - DIV_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign zero = (cnt_q == '0);

endmodule

// File: rtl/note_tone_gen.sv
// Square-wave tone generator driven by the melody sequencer's note index.
// Ports: clk, rst_n (async, active-low); note[4:0] (0..24 semitones above
// C4, 25..31 rest); spk = 50 % duty square wave, low when silent;
// sounding = high while the tone is actively toggling.
// Optional feature macro TONE_ARTIC_EN: each change to a sounding note is
// preceded by ARTIC_CYCLES cycles of silence (GAP state).
module note_tone_gen
  import tone_pkg::*;
#(
  parameter int unsigned CLK_HZ       = 50000000,
  parameter int unsigned ARTIC_CYCLES = 500000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NOTE_W-1:0] note,
  output logic              spk,
  output logic              sounding
);

  tone_state_t       state_q, state_d;
  logic [NOTE_W-1:0] note_q, note_d;
  logic [NOTE_W-1:0] cur_note_q, cur_note_d;
  logic              spk_q, spk_d;
  logic              sounding_q, sounding_d;
`ifdef TONE_ARTIC_EN
  logic [GAP_W-1:0]  gap_cnt_q, gap_cnt_d;
`endif

  logic              cnt_load, cnt_en, cnt_zero;
  logic [DIV_W-1:0]  cnt_load_val;
  logic [DIV_W-1:0]  div_m1_c;
  logic              change_c, is_sound_c;
  logic              cfg_unused_c;

  // The divider table is fixed to a 50 MHz clock; parameters sink here.
  assign cfg_unused_c = ^{32'(CLK_HZ), 32'(ARTIC_CYCLES)};

  assign div_m1_c   = half_period(note_q) - DIV_W'(1);
  assign change_c   = (note_q != cur_note_q);
  assign is_sound_c = (note_q < NOTE_REST);

  tone_half_period_cnt u_cnt (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (cnt_load),
    .load_val (cnt_load_val),
    .enable   (cnt_en),
    .zero     (cnt_zero)
  );

  // Next-state logic; a note change always beats a pending toggle.
  always_comb begin
    state_d      = state_q;
    note_d       = note;
    cur_note_d   = cur_note_q;
    spk_d        = spk_q;
    cnt_load     = 1'b0;
    cnt_load_val = '0;
    cnt_en       = 1'b0;
`ifdef TONE_ARTIC_EN
    gap_cnt_d    = gap_cnt_q;
`endif

    if (change_c) cur_note_d = note_q;

    case (state_q)
      ST_IDLE: begin
        spk_d    = 1'b0;
        cnt_load = 1'b1;
        if (change_c && is_sound_c) begin
`ifdef TONE_ARTIC_EN
          state_d   = ST_GAP;
          gap_cnt_d = GAP_W'(ARTIC_CYCLES - 1);
`else
          state_d      = ST_RUN;
          cnt_load_val = div_m1_c;
`endif
        end
      end

`ifdef TONE_ARTIC_EN
      ST_GAP: begin
        spk_d    = 1'b0;
        cnt_load = 1'b1;
        if (change_c) begin
          if (is_sound_c) gap_cnt_d = GAP_W'(ARTIC_CYCLES - 1);
          else            state_d   = ST_IDLE;
        end else if (gap_cnt_q == '0) begin
          state_d      = ST_RUN;
          cnt_load_val = div_m1_c;
        end else begin
          gap_cnt_d = gap_cnt_q - GAP_W'(1);
        end
      end
`endif

      ST_RUN: begin
        if (change_c) begin
          spk_d    = 1'b0;
          cnt_load = 1'b1;
          if (!is_sound_c) begin
            state_d = ST_IDLE;
          end else begin
`ifdef TONE_ARTIC_EN
            state_d   = ST_GAP;
            gap_cnt_d = GAP_W'(ARTIC_CYCLES - 1);
`else
            cnt_load_val = div_m1_c;
`endif
          end
        end else if (cnt_zero) begin
          spk_d        = ~spk_q;
          cnt_load     = 1'b1;
          cnt_load_val = div_m1_c;
        end else begin
          cnt_en = 1'b1;
        end
      end

      default: begin
        state_d  = ST_IDLE;
        spk_d    = 1'b0;
        cnt_load = 1'b1;
      end
    endcase

    sounding_d = (state_d == ST_RUN);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      note_q     <= NOTE_REST;
      cur_note_q <= NOTE_REST;
      spk_q      <= 1'b0;
      sounding_q <= 1'b0;
`ifdef TONE_ARTIC_EN
      gap_cnt_q  <= '0;
`endif
    end else begin
      state_q    <= state_d;
      note_q     <= note_d;
      cur_note_q <= cur_note_d;
      spk_q      <= spk_d;
      sounding_q <= sounding_d;
`ifdef TONE_ARTIC_EN
      gap_cnt_q  <= gap_cnt_d;
`endif
    end
  end

  assign spk      = spk_q;
  assign sounding = sounding_q;

endmodule

// File: tb/tb_note_tone_gen.sv
// Bench for note_tone_gen: timing model plus directed hand-computed checks.
// With TONE_ARTIC_EN defined the DUT is built with a 100-cycle gap.
module tb_note_tone_gen;

`ifdef TONE_ARTIC_EN
  localparam int unsigned ARTIC = 100;
  localparam int MODEL_GAP = 100;
`else
  localparam int unsigned ARTIC = 500000;
  localparam int MODEL_GAP = 0;
`endif

  logic       clk = 1'b0;
  logic       rst_n;
  logic [4:0] note;
  logic       spk;
  logic       sounding;

  int n_chk  = 0;
  int n_pass = 0;

  // Model state: edge count since reset release, pitch table, note timing.
  int         tbl [0:24];
  int         cyc;
  int         m_t0, m_d;
  bit         m_run;
  logic [4:0] m_nq, m_cur;

  always #5 clk = ~clk;

  note_tone_gen #(.CLK_HZ(50000000), .ARTIC_CYCLES(ARTIC)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .note     (note),
    .spk      (spk),
    .sounding (sounding)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (cyc %0d)", name, act, exp, cyc);
  endtask

  // Behavioural model: a note heard from load edge t0 with half period d
  // is high on edges where floor((t - t0) / d) is odd.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cyc   = 0;
      m_run = 0;
      m_t0  = 0;
      m_d   = 1;
      m_nq  = 5'd25;
      m_cur = 5'd25;
    end else begin
      cyc = cyc + 1;
      if (m_nq != m_cur) begin
        m_cur = m_nq;
        if (m_nq < 5'd25) begin
          m_run = 1;
          m_t0  = cyc + MODEL_GAP;
          m_d   = tbl[m_nq];
        end else begin
          m_run = 0;
        end
      end
      m_nq = note;
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      int exp_spk, exp_snd;
      exp_snd = (m_run && cyc >= m_t0) ? 1 : 0;
      exp_spk = exp_snd ? (((cyc - m_t0) / m_d) % 2) : 0;
      check("model_spk", 32'(spk), 32'(exp_spk));
      check("model_sounding", 32'(sounding), 32'(exp_snd));
    end
  end

  task automatic wait_cyc(input int t);
    while (cyc < t) @(negedge clk);
  endtask

  initial begin
    #(10 * 150000);
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    real r;
    r = 1.0;
    for (int n = 0; n < 25; n++) begin
      tbl[n] = int'(50000000.0 / (2.0 * 261.626 * r));
      r = r * 1.0594630943592953;
    end
    check("tbl_c4", 32'(tbl[0]), 32'd95556);
    check("tbl_g4", 32'(tbl[7]), 32'd63776);
    check("tbl_a4", 32'(tbl[9]), 32'd56818);
    check("tbl_c5", 32'(tbl[12]), 32'd47778);
    check("tbl_c6", 32'(tbl[24]), 32'd23889);

    rst_n = 1'b0;
    note  = 5'd25;
    repeat (3) @(negedge clk);
    note = 5'd3;
    @(negedge clk);
    check("reset_spk", 32'(spk), 32'd0);
    check("reset_sounding", 32'(sounding), 32'd0);

`ifdef TONE_ARTIC_EN
    rst_n = 1'b1;
    note  = 5'd4;
    wait_cyc(101); check("gap_silent_snd", 32'(sounding), 32'd0);
    wait_cyc(102); check("gap_end_snd", 32'(sounding), 32'd1);
                   check("gap_end_spk", 32'(spk), 32'd0);
    wait_cyc(200); note = 5'd7;
    wait_cyc(202); check("regap_snd", 32'(sounding), 32'd0);
    wait_cyc(301); check("regap_hold_snd", 32'(sounding), 32'd0);
                   check("regap_hold_spk", 32'(spk), 32'd0);
    wait_cyc(302); check("regap_end_snd", 32'(sounding), 32'd1);
    wait_cyc(400); note = 5'd7;
    wait_cyc(500); check("legato_snd", 32'(sounding), 32'd1);
    note = 5'd25;
    wait_cyc(502); check("artic_rest_snd", 32'(sounding), 32'd0);
`else
    rst_n = 1'b1;
    note  = 5'd24;
    wait_cyc(1);     check("e1_sounding", 32'(sounding), 32'd0);
    wait_cyc(2);     check("e2_sounding", 32'(sounding), 32'd1);
                     check("e2_spk", 32'(spk), 32'd0);
    wait_cyc(23890); check("pre_rise_spk", 32'(spk), 32'd0);
    wait_cyc(23891); check("first_rise_spk", 32'(spk), 32'd1);
    // Mid-half-period change: pin goes low at the load edge.
    wait_cyc(30000); note = 5'd23;
    wait_cyc(30001); check("pre_change_spk", 32'(spk), 32'd1);
    wait_cyc(30002); check("phase_restart_spk", 32'(spk), 32'd0);
                     check("phase_restart_snd", 32'(sounding), 32'd1);
    // Change lands on the edge where note 23 would have risen.
    wait_cyc(55310); note = 5'd24;
    wait_cyc(55311); check("pre_coincide_spk", 32'(spk), 32'd0);
    wait_cyc(55312); check("coincide_no_toggle", 32'(spk), 32'd0);
    wait_cyc(55400); note = 5'd7;
    wait_cyc(55500); note = 5'd25;
    wait_cyc(55501); check("rest_pre_snd", 32'(sounding), 32'd1);
    wait_cyc(55502); check("rest_snd", 32'(sounding), 32'd0);
                     check("rest_spk", 32'(spk), 32'd0);
    for (int v = 26; v < 32; v++) begin
      int b;
      b = 55600 + (v - 26) * 40;
      wait_cyc(b);      note = 5'd5;
      wait_cyc(b + 20); note = 5'(v);
      wait_cyc(b + 21); check("rest_hi_pre_snd", 32'(sounding), 32'd1);
      wait_cyc(b + 22); check("rest_hi_snd", 32'(sounding), 32'd0);
    end
    wait_cyc(55900); note = 5'd24;
    wait_cyc(55950);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_spk", 32'(spk), 32'd0);
    check("async_rst_snd", 32'(sounding), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    wait_cyc(1); check("relaunch_e1_snd", 32'(sounding), 32'd0);
    wait_cyc(2); check("relaunch_e2_snd", 32'(sounding), 32'd1);
    wait_cyc(10);
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
